cdc_pulse: RTL and testbench



---
 rtl/cdc_pkg.sv | 18 +
 rtl/cdc_sync_bit.sv | 41 ++++
 rtl/cdc_pulse.sv | 47 ++++
 tb/tb_cdc_pulse.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/cdc_pkg.sv
// Purpose : shared constants for single-bit clock-domain-crossing blocks.
// Latency : n/a (package only).
// Backpressure: n/a; consumers receive events and cannot stall the source.
package cdc_pkg;

    // Synchronizer depth used when an instance does not override it.
    localparam int CDC_SYNC_STAGES_DEFAULT = 2;

    // Shallowest chain that still gives a full clock period of settling time
    // before the sampled value reaches logic that fans out.
    localparam int CDC_SYNC_STAGES_MIN = 2;

    // True when a requested depth is acceptable for a synchronizer chain.
    function automatic bit cdc_stages_legal(input int stages);
        return stages >= CDC_SYNC_STAGES_MIN;
    endfunction

endpackage

// File: rtl/cdc_sync_bit.sv
// Purpose : N-flop single-bit level synchronizer into the clk domain.
// Latency : STAGES clk edges from a settled input to q (plus up to one edge of metastability).
// Backpressure: none; the input is sampled every cycle and cannot be stalled.
//
// Ports:
//   clk - destination clock
//   rst - asynchronous active-high reset, clears the whole chain
//   d   - asynchronous input level
//   q   - synchronized level, output of the last chain flop
module cdc_sync_bit
    import cdc_pkg::*;
#(
    parameter int STAGES = CDC_SYNC_STAGES_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    // A chain shorter than two flops gives no settling time at all; refuse to build.
    if (!cdc_stages_legal(STAGES)) begin : g_bad_stages
        $error("cdc_sync_bit: STAGES must be at least %0d", CDC_SYNC_STAGES_MIN);
    end

    // Only chain[0] may go metastable. The attributes keep the flops packed
    // together and stop the tools from retiming or turning them into an SRL.
    (* ASYNC_REG = "TRUE", shreg_extract = "no", dont_retime = "true" *)
    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/cdc_pulse.sv
// Purpose : turn each rising edge of an asynchronous event level into one clk-cycle pulse.
// Latency : SYNC_STAGES+1 clk edges from the first edge that samples pulse_a high (+1 for metastability).
// Backpressure: none; the source must hold high >=2 and low >=2 clk periods or events merge/drop.
//
// Ports:
//   clk     - local (destination) clock
//   rst     - asynchronous active-high reset, clears all state immediately
//   pulse_a - asynchronous event level from the source domain; events are rising edges
//   pulse_b - registered single-cycle pulse, one per detected event
module cdc_pulse
    import cdc_pkg::*;
#(
    parameter int SYNC_STAGES = CDC_SYNC_STAGES_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic pulse_a,
    output logic pulse_b
);

    logic sync_q;   // pulse_a after the synchronizer chain
    logic prev;     // sync_q delayed one cycle, for edge detection

    cdc_sync_bit #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (pulse_a),
        .q   (sync_q)
    );

    // Because prev clears on reset, a pulse_a level that is already high
    // when reset releases is seen as a fresh rising edge.
    // pulse_b is a flop so that downstream logic never sees a glitch; it can
    // only be high when prev was low, so two consecutive highs are impossible.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev    <= 1'b0;
            pulse_b <= 1'b0;
        end else begin
            prev    <= sync_q;
            pulse_b <= sync_q & ~prev;
        end
    end

endmodule

// File: tb/tb_cdc_pulse.sv
module tb_cdc_pulse;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic pulse_a;
    logic pulse_b2;
    logic pulse_b3;

    cdc_pulse #(.SYNC_STAGES(2)) dut2 (
        .clk     (clk),
        .rst     (rst),
        .pulse_a (pulse_a),
        .pulse_b (pulse_b2)
    );

    cdc_pulse #(.SYNC_STAGES(3)) dut3 (
        .clk     (clk),
        .rst     (rst),
        .pulse_a (pulse_a),
        .pulse_b (pulse_b3)
    );

    int tests = 0;
    int fails = 0;

    task automatic check_bit(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Watch for pulse_b high in two consecutive cycles on either instance.
    int  consec = 0;
    logic last2 = 1'b0;
    logic last3 = 1'b0;
    always @(negedge clk) begin
        if (pulse_b2 === 1'b1 && last2 === 1'b1) consec++;
        if (pulse_b3 === 1'b1 && last3 === 1'b1) consec++;
        last2 = pulse_b2;
        last3 = pulse_b3;
    end

    // One vector = inputs applied before an edge, expected outputs after it.
    typedef struct {
        logic rst;
        logic pa;
        logic b2;
        logic b3;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic a, input logic e2, input logic e3);
        vec_t v;
        v.rst = r;
        v.pa  = a;
        v.b2  = e2;
        v.b3  = e3;
        vecs.push_back(v);
    endtask

    initial begin
        int cyc;
        int cnt2;
        int cnt3;
        int fall_cnt;
        int t2[$];

        rst     = 1'b1;
        pulse_a = 1'b0;
        #1;
        check_bit("reset_b2", pulse_b2, 1'b0);
        check_bit("reset_b3", pulse_b3, 1'b0);
        tick;

        // Single 3-cycle event: E0 is the edge of the 3rd vector.
        add(1,0,0,0); add(0,0,0,0);
        add(0,1,0,0); add(0,1,0,0); add(0,1,1,0); add(0,0,0,1);
        add(0,0,0,0); add(0,0,0,0); add(0,0,0,0);
        // Reset for one cycle at E0+1 with pulse_a held high; one pulse after release.
        add(0,1,0,0); add(1,1,0,0);
        add(0,1,0,0); add(0,1,0,0); add(0,1,1,0); add(0,1,0,1); add(0,1,0,0);
        add(0,0,0,0); add(0,0,0,0); add(0,0,0,0); add(0,0,0,0);
        // pulse_a already high while reset is held, then released.
        add(1,1,0,0); add(1,1,0,0);
        add(0,1,0,0); add(0,1,0,0); add(0,1,1,0); add(0,0,0,1);
        add(0,0,0,0); add(0,0,0,0); add(0,0,0,0); add(0,0,0,0);
        // One-cycle pulse (outside the contract) still yields one narrow pulse.
        add(0,1,0,0); add(0,0,0,0); add(0,0,1,0); add(0,0,0,1);
        add(0,0,0,0); add(0,0,0,0); add(0,0,0,0);

        for (int i = 0; i < vecs.size(); i++) begin
            rst     = vecs[i].rst;
            pulse_a = vecs[i].pa;
            tick;
            check_bit($sformatf("vec%0d_b2", i), pulse_b2, vecs[i].b2);
            check_bit($sformatf("vec%0d_b3", i), pulse_b3, vecs[i].b3);
        end

        // Reset hold: pulse_a toggles every 3 cycles, outputs stay low.
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            pulse_a = ((i / 3) % 2) == 1;
            tick;
            check_bit($sformatf("hold%0d_b2", i), pulse_b2, 1'b0);
            check_bit($sformatf("hold%0d_b3", i), pulse_b3, 1'b0);
        end
        pulse_a = 1'b0;
        tick;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) tick;

        // Burst: 10 events, 2 high + 4 low each.
        cyc  = 0;
        cnt2 = 0;
        cnt3 = 0;
        for (int ev = 0; ev < 10; ev++) begin
            for (int k = 0; k < 6; k++) begin
                pulse_a = (k < 2);
                tick;
                if (pulse_b2 === 1'b1) begin cnt2++; t2.push_back(cyc); end
                if (pulse_b3 === 1'b1) cnt3++;
                cyc++;
            end
        end
        pulse_a = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick;
            if (pulse_b2 === 1'b1) begin cnt2++; t2.push_back(cyc); end
            if (pulse_b3 === 1'b1) cnt3++;
            cyc++;
        end
        check_int("burst_count_b2", cnt2, 10);
        check_int("burst_count_b3", cnt3, 10);
        if (t2.size() > 0) check_int("burst_first_latency_b2", t2[0], 2);
        else check_int("burst_first_latency_b2", -1, 2);
        for (int i = 1; i < t2.size(); i++)
            check_int($sformatf("burst_spacing%0d", i), t2[i] - t2[i-1], 6);

        // Long level: one pulse, nothing on the falling edge.
        cnt2 = 0;
        cnt3 = 0;
        fall_cnt = 0;
        pulse_a = 1'b1;
        for (int k = 0; k < 50; k++) begin
            tick;
            if (pulse_b2 === 1'b1) cnt2++;
            if (pulse_b3 === 1'b1) cnt3++;
        end
        pulse_a = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick;
            if (pulse_b2 === 1'b1) fall_cnt++;
            if (pulse_b3 === 1'b1) fall_cnt++;
        end
        check_int("long_count_b2", cnt2, 1);
        check_int("long_count_b3", cnt3, 1);
        check_int("long_fall_pulses", fall_cnt, 0);

        // Asynchronous reset drops a pulse already on the output.
        pulse_a = 1'b1;
        tick;
        tick;
        tick;
        check_bit("async_pre_b2", pulse_b2, 1'b1);
        rst = 1'b1;
        #1;
        check_bit("async_drop_b2", pulse_b2, 1'b0);
        tick;
        check_bit("async_inflight_b3", pulse_b3, 1'b0);
        pulse_a = 1'b0;
        rst = 1'b0;
        cnt2 = 0;
        cnt3 = 0;
        for (int k = 0; k < 6; k++) begin
            tick;
            if (pulse_b2 === 1'b1) cnt2++;
            if (pulse_b3 === 1'b1) cnt3++;
        end
        check_int("async_after_b2", cnt2, 0);
        check_int("async_after_b3", cnt3, 0);

        check_int("no_consecutive_highs", consec, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
